// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: sequential-PC instruction fetch with 1-cycle memory, instruction FIFO and redirect flush
// Ports:
//   clk, reset                    clock and asynchronous active-high reset
//   enable                        global stall; shared with the program memory enable
//   o_read, o_pc                  read strobe and fetch address to program memory
//   i_valid, i_instr              program memory response (1-cycle latency, held while enable=0)
//   i_redirect, i_redirect_pc     branch/jump redirect: flush FIFO, squash in-flight read, refetch
//   o_instr_valid, o_instr,
//   o_instr_pc, i_instr_ready     decode-side valid/ready handshake
// Optional feature: define RISCV_FETCH_BYPASS_EN to forward a response straight to decode
// when the FIFO is empty and decode is ready.
module riscv_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   o_read,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    input  logic                   i_valid,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic                   i_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    output logic                   o_instr_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_instr_pc,
    input  logic                   i_instr_ready
);
    localparam int                    PW       = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_MASK  = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] START_PC = RESET_PC & PC_MASK;
    localparam logic [PW:0]           DEPTH_C  = (PW+1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0]  pc_r, meta_pc;
    logic                   inflight, kill;
    logic [PW-1:0]          head, tail;
    logic [PW:0]            count;
    logic [INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem    [FIFO_DEPTH];
    logic                   empty, accept, live, bypass, push, pop;

    always_comb begin
        empty  = count == '0;
        // i_valid is held by the memory during stalls, so only trust it while a read is outstanding
        accept = inflight && i_valid;
        live   = accept && !kill && !i_redirect;
`ifdef RISCV_FETCH_BYPASS_EN
        bypass = live && empty && i_instr_ready;
`else
        bypass = 1'b0;
`endif
        push   = live && !bypass;
        pop    = !empty && i_instr_ready && !i_redirect;
        // credit = stored entries + outstanding read; never issue a second read before the first returns
        o_read = !reset && enable && !i_redirect && (!inflight || accept) &&
                 (count + (PW+1)'(inflight)) < DEPTH_C;
        o_pc          = pc_r;
        o_instr_valid = !empty || bypass;
        o_instr       = !empty ? instr_mem[head] : bypass ? i_instr : '0;
        o_instr_pc    = !empty ? pc_mem[head]    : bypass ? meta_pc : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r     <= START_PC;
            meta_pc  <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (i_redirect) begin
                pc_r  <= i_redirect_pc & PC_MASK;
                head  <= '0;
                tail  <= '0;
                count <= '0;
                // a read still outstanding after this cycle belongs to the old path
                kill  <= inflight && !accept;
            end else begin
                if (o_read) pc_r <= pc_r + ADDR_WIDTH'(4);
                head  <= head + PW'(pop);
                tail  <= tail + PW'(push);
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
                if (accept) kill <= 1'b0;
            end
            if (o_read) begin
                meta_pc  <= pc_r;
                inflight <= 1'b1;
            end else if (accept) begin
                inflight <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail] <= i_instr;
            pc_mem[tail]    <= meta_pc;
        end
    end
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: directed bench for riscv_fetch_unit with a 1-cycle program memory model
module tb_riscv_fetch_unit;
    localparam int AW = 64;
    localparam int IW = 32;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] RPC = 64'h100;
`ifdef RISCV_FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          o_read;
    logic [AW-1:0] o_pc;
    logic          i_valid;
    logic [IW-1:0] i_instr;
    logic          i_redirect = 1'b0;
    logic [AW-1:0] i_redirect_pc = '0;
    logic          o_instr_valid;
    logic [IW-1:0] o_instr;
    logic [AW-1:0] o_instr_pc;
    logic          i_instr_ready = 1'b0;
    int            errors = 0;
    int            checks = 0;

    riscv_fetch_unit #(
        .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .o_read(o_read), .o_pc(o_pc),
        .i_valid(i_valid), .i_instr(i_instr), .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc), .o_instr_valid(o_instr_valid), .o_instr(o_instr),
        .o_instr_pc(o_instr_pc), .i_instr_ready(i_instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] f(input logic [AW-1:0] pc);
        return pc[31:0] ^ 32'hDEAD_0003;
    endfunction

    // program memory: registered response, holds its outputs while enable=0
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            i_valid <= 1'b0;
            i_instr <= '0;
        end else if (enable) begin
            i_valid <= o_read;
            i_instr <= f(o_pc);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        reset = 1'b1;
        i_redirect = 1'b0;
        enable = 1'b1;
        i_instr_ready = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        enable = 1'b1;
        i_instr_ready = 1'b1;
        tick;
        checks++; if (o_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", o_read); end
        checks++; if (o_pc !== RPC) begin errors++; $display("FAIL reset_pc: got %h want %h", o_pc, RPC); end
        checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_instr_valid); end
        checks++; if (o_instr !== '0) begin errors++; $display("FAIL reset_instr: got %h want 0", o_instr); end
        checks++; if (o_instr_pc !== '0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", o_instr_pc); end
    endtask

    task automatic test_sequential;
        logic [AW-1:0] exp;
        reset_dut;
        for (int k = 0; k < 8; k++) begin
            exp = RPC + AW'(4 * k);
            checks++;
            if (o_read !== 1'b1 || o_pc !== exp) begin
                errors++; $display("FAIL seq_issue[%0d]: got read=%b pc=%h want read=1 pc=%h", k, o_read, o_pc, exp);
            end
            if (k >= LAT) begin
                exp = RPC + AW'(4 * (k - LAT));
                checks++;
                if (o_instr_valid !== 1'b1 || o_instr_pc !== exp || o_instr !== f(exp)) begin
                    errors++; $display("FAIL seq_decode[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                                       k, o_instr_valid, o_instr_pc, o_instr, exp, f(exp));
                end
            end else begin
                checks++;
                if (o_instr_valid !== 1'b0) begin
                    errors++; $display("FAIL seq_early_valid[%0d]: got %b want 0", k, o_instr_valid);
                end
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        int reads = 0;
        int got = 0;
        reset_dut;
        i_instr_ready = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (o_read) reads++;
            tick;
        end
        checks++; if (reads != DEPTH) begin errors++; $display("FAIL bp_reads: got %0d want %0d", reads, DEPTH); end
        checks++; if (o_read !== 1'b0) begin errors++; $display("FAIL bp_read_stop: got %b want 0", o_read); end
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr_pc !== RPC) begin
            errors++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=%h", o_instr_valid, o_instr_pc, RPC);
        end
        i_instr_ready = 1'b1;
        #1;
        for (int c = 0; c < 20 && got < 8; c++) begin
            if (o_instr_valid) begin
                checks++;
                if (o_instr_pc !== RPC + AW'(4 * got)) begin
                    errors++; $display("FAIL bp_pop[%0d]: got %h want %h", got, o_instr_pc, RPC + AW'(4 * got));
                end
                got++;
            end
            tick;
        end
        checks++; if (got != 8) begin errors++; $display("FAIL bp_pop_count: got %0d want 8", got); end
    endtask

    task automatic test_redirect;
        int c = 0;
        reset_dut;
        tick; tick; tick;
        i_redirect = 1'b1;
        i_redirect_pc = 64'h203;
        #1;
        checks++; if (o_read !== 1'b0) begin errors++; $display("FAIL redir_no_issue: got %b want 0", o_read); end
        tick;
        i_redirect = 1'b0;
        #1;
        checks++;
        if (o_pc !== 64'h200 || o_read !== 1'b1) begin
            errors++; $display("FAIL redir_pc: got read=%b pc=%h want read=1 pc=200", o_read, o_pc);
        end
        checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b want 0", o_instr_valid); end
        while (!o_instr_valid && c < 8) begin tick; c++; end
        checks++;
        if (c != LAT || o_instr_pc !== 64'h200 || o_instr !== f(64'h200)) begin
            errors++; $display("FAIL redir_first: got lat=%0d pc=%h i=%h want lat=%0d pc=200 i=%h",
                               c, o_instr_pc, o_instr, LAT, f(64'h200));
        end
    endtask

    task automatic test_enable;
        int en_seq [12] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0, 1};
        int issued = 0;
        int got = 0;
        reset_dut;
        for (int i = 0; i < 18; i++) begin
            enable = (i < 12) ? en_seq[i][0] : 1'b0;
            #1;
            checks++;
            if (o_pc !== RPC + AW'(4 * issued) || o_read !== enable) begin
                errors++; $display("FAIL en_issue[%0d]: got read=%b pc=%h want read=%b pc=%h",
                                   i, o_read, o_pc, enable, RPC + AW'(4 * issued));
            end
            if (o_instr_valid) begin
                checks++;
                if (o_instr_pc !== RPC + AW'(4 * got) || o_instr !== f(RPC + AW'(4 * got))) begin
                    errors++; $display("FAIL en_deliver[%0d]: got pc=%h i=%h want pc=%h", got, o_instr_pc, o_instr,
                                       RPC + AW'(4 * got));
                end
                got++;
            end
            if (enable) issued++;
            tick;
        end
        checks++; if (got != issued) begin errors++; $display("FAIL en_count: got %0d want %0d", got, issued); end
        enable = 1'b1;
    endtask

    task automatic test_wrap;
        int c = 0;
        reset_dut;
        i_redirect = 1'b1;
        i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        tick;
        i_redirect = 1'b0;
        #1;
        checks++;
        if (o_pc !== 64'hFFFF_FFFF_FFFF_FFFC || o_read !== 1'b1) begin
            errors++; $display("FAIL wrap_top: got read=%b pc=%h want read=1 pc=fffffffffffffffc", o_read, o_pc);
        end
        tick;
        checks++; if (o_pc !== 64'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", o_pc); end
        while (!o_instr_valid && c < 8) begin tick; c++; end
        checks++;
        if (o_instr_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++; $display("FAIL wrap_deliver_top: got %h want fffffffffffffffc", o_instr_pc);
        end
        tick;
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr_pc !== 64'h0) begin
            errors++; $display("FAIL wrap_deliver_zero: got v=%b pc=%h want v=1 pc=0", o_instr_valid, o_instr_pc);
        end
    endtask

    task automatic test_reset_mid;
        int c = 0;
        reset_dut;
        i_instr_ready = 1'b0;
        tick; tick; tick; tick;
        checks++;
        if (o_instr_valid !== 1'b1 || o_read !== 1'b0) begin
            errors++; $display("FAIL mid_fill: got v=%b read=%b want v=1 read=0", o_instr_valid, o_read);
        end
        reset = 1'b1;
        #1;
        checks++; if (o_instr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", o_instr_valid); end
        checks++; if (o_instr_pc !== '0) begin errors++; $display("FAIL mid_instr_pc: got %h want 0", o_instr_pc); end
        checks++; if (o_read !== 1'b0) begin errors++; $display("FAIL mid_read: got %b want 0", o_read); end
        tick;
        reset = 1'b0;
        i_instr_ready = 1'b1;
        #1;
        checks++;
        if (o_pc !== RPC || o_read !== 1'b1) begin
            errors++; $display("FAIL mid_restart: got read=%b pc=%h want read=1 pc=%h", o_read, o_pc, RPC);
        end
        while (!o_instr_valid && c < 8) begin tick; c++; end
        checks++;
        if (c != LAT || o_instr_pc !== RPC) begin
            errors++; $display("FAIL mid_first: got lat=%0d pc=%h want lat=%0d pc=%h", c, o_instr_pc, LAT, RPC);
        end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_backpressure;
        test_redirect;
        test_enable;
        test_wrap;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
